// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: one skip block per pipeline stage,
// with a valid/ready handshake through the stages and a registered result.
module pipelined_carry_skip_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 c_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 c_out,
    output logic                 overflow,
    output logic [WIDTH/BLK-1:0] bypass
);

    localparam int NBLK = WIDTH / BLK;

    logic [NBLK-1:0]  v_q;
    logic [WIDTH-1:0] a_q   [NBLK];
    logic [WIDTH-1:0] b_q   [NBLK];
    logic [WIDTH-1:0] s_q   [NBLK];
    logic [NBLK-1:0]  byp_q [NBLK];
    logic [NBLK-1:0]  c_q;
    logic             cmsb_q;

    logic [WIDTH-1:0] src_a   [NBLK];
    logic [WIDTH-1:0] src_b   [NBLK];
    logic [WIDTH-1:0] src_s   [NBLK];
    logic [NBLK-1:0]  src_byp [NBLK];
    logic [NBLK-1:0]  src_c;
    logic [NBLK-1:0]  src_v;

    logic [BLK-1:0]   p     [NBLK];
    logic [BLK:0]     rc    [NBLK];
    logic [WIDTH-1:0] s_n   [NBLK];
    logic [NBLK-1:0]  byp_n [NBLK];
    logic [NBLK-1:0]  c_n;
    logic             cmsb_n;

    logic [NBLK-1:0]  rdy;
    logic [NBLK-1:0]  adv;

    // Stage i sees either the live operands (i = 0) or the previous stage's
    // registers, and resolves exactly one skip block.
    always_comb begin
        src_c = '0;
        src_v = '0;
        c_n   = '0;
        src_a[0]   = a;
        src_b[0]   = sub ? ~b : b;
        src_s[0]   = '0;
        src_byp[0] = '0;
        src_c[0]   = sub | c_in;
        src_v[0]   = in_valid;
        for (int i = 1; i < NBLK; i++) begin
            src_a[i]   = a_q[i-1];
            src_b[i]   = b_q[i-1];
            src_s[i]   = s_q[i-1];
            src_byp[i] = byp_q[i-1];
            src_c[i]   = c_q[i-1];
            src_v[i]   = v_q[i-1];
        end
        for (int i = 0; i < NBLK; i++) begin
            p[i]     = src_a[i][i*BLK +: BLK] ^ src_b[i][i*BLK +: BLK];
            rc[i][0] = src_c[i];
            for (int k = 0; k < BLK; k++) begin
                rc[i][k+1] = (src_a[i][i*BLK+k] & src_b[i][i*BLK+k]) | (p[i][k] & rc[i][k]);
            end
            s_n[i] = src_s[i];
            s_n[i][i*BLK +: BLK] = p[i] ^ rc[i][BLK-1:0];
            byp_n[i]    = src_byp[i];
            byp_n[i][i] = &p[i];
            c_n[i] = byp_n[i][i] ? src_c[i] : rc[i][BLK];
        end
        cmsb_n = rc[NBLK-1][BLK-1];
    end

    // A stage may accept when empty or when everything downstream can move.
    always_comb begin : ready_chain
        logic chain;
        rdy   = '0;
        chain = out_ready;
        for (int i = NBLK - 1; i >= 0; i--) begin
            rdy[i] = chain;
            chain  = chain | ~v_q[i];
        end
    end

    assign adv      = ~v_q | rdy;
    assign in_ready = rst_n & adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            cmsb_q <= 1'b0;
            for (int i = 0; i < NBLK; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                s_q[i]   <= '0;
                byp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBLK; i++) begin
                if (adv[i]) begin
                    v_q[i] <= src_v[i];
                    if (src_v[i]) begin
                        a_q[i]   <= src_a[i];
                        b_q[i]   <= src_b[i];
                        s_q[i]   <= s_n[i];
                        byp_q[i] <= byp_n[i];
                        c_q[i]   <= c_n[i];
                    end
                end
            end
            if (adv[NBLK-1] && src_v[NBLK-1]) begin
                cmsb_q <= cmsb_n;
            end
        end
    end

    assign out_valid = v_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign c_out     = c_q[NBLK-1];
    assign overflow  = cmsb_q ^ c_q[NBLK-1];
    assign bypass    = byp_q[NBLK-1];

endmodule

// File: doc/pipelined_carry_skip_adder.md
PIPELINED_CARRY_SKIP_ADDER -- requirements
Module: pipelined_carry_skip_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter BLK, default 4, skip-block width in bits; WIDTH SHALL be an integer multiple of BLK; NBLK = WIDTH/BLK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry-out of the MSB (for sub: 1 = no borrow).
REQ-015 overflow  output  1  two's-complement signed overflow.
REQ-016 bypass  output  NBLK  bit i = 1 when block i's carry-out was taken from the skip path.

Function
REQ-017 Effective operands SHALL be a, b_eff = sub ? ~b : b, and cin_eff = sub ? 1 : c_in.
REQ-018 Block i (bits i*BLK+BLK-1 .. i*BLK) SHALL form p = a ^ b_eff; P_i = AND of all p bits in the block.
REQ-019 The block carry-out SHALL be cin_blk when P_i = 1 (skip path), otherwise the internal ripple carry; bypass[i] = P_i.
REQ-020 The pipeline SHALL have NBLK register stages; stage i computes block i using the carry registered by stage i-1 (stage 0 uses cin_eff).
REQ-021 Each stage SHALL carry forward a valid bit, the remaining unprocessed operand bits, completed sum bits, the block carry, the bypass bits so far, and the carry into the MSB.
REQ-022 overflow SHALL equal (carry into MSB) XOR c_out.
REQ-023 A beat SHALL be accepted when in_valid & in_ready at a rising edge.
REQ-024 Stage i SHALL advance when valid_i = 1 and ready_i = 1; ready_(NBLK-1) = out_ready; ready_i = ~valid_(i+1) | ready_(i+1); in_ready = ~valid_0 | ready_0.
REQ-025 Latency SHALL be NBLK edges: a beat accepted at edge E drives out_valid from edge E+NBLK-1 onward, provided no stall occurred.
REQ-026 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-027 When out_valid = 1 and out_ready = 0, sum, c_out, overflow, bypass and out_valid SHALL hold stable.
REQ-028 A stalled stage SHALL hold its contents.
REQ-029 At most NBLK beats SHALL be in flight.
REQ-030 Beats SHALL exit in acceptance order with no loss or duplication.
REQ-031 in_ready SHALL remain 1 with a full pipeline when out_ready = 1 (simultaneous pop and push).
REQ-032 a, b, c_in and sub SHALL only be sampled on accept; values on non-accepted cycles have no effect.
REQ-033 Arithmetic SHALL be modulo 2^WIDTH; c_out SHALL be the (WIDTH+1)th bit.
REQ-034 NBLK = 1 SHALL degenerate to a single registered stage with latency 1.

Reset
REQ-035 rst_n = 0 SHALL immediately clear every stage valid bit and drive out_valid = 0, sum = 0, c_out = 0, overflow = 0 and bypass = 0, independent of clk.
REQ-036 While rst_n = 0, in_ready SHALL be 0.
REQ-037 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after release.
REQ-038 The first accept after release SHALL be possible at the first rising edge with rst_n = 1.

Verification (WIDTH=16, BLK=4 unless stated)
REQ-039 Add a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0, bypass=4'b1110, out_valid 4 edges after accept.
REQ-040 Add a=0x00FF, b=0xFF00, c_in=1 -> sum=0x0000, c_out=1, overflow=0, bypass=4'b1111 (full skip chain).
REQ-041 Sub a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, overflow=1, bypass=4'b0110.
REQ-042 Backpressure: 6 back-to-back beats with out_ready=0 for 5 cycles -> in_ready falls after 4 accepts, outputs hold stable while stalled, all 6 results exit in order with correct values, no duplicates.
REQ-043 Reset mid-flight: 3 beats in flight, pulse rst_n low between edges -> out_valid=0 immediately, no stale result after release, next beat has latency 4.
REQ-044 WIDTH=8, BLK=8: a=0x7F, b=0x01 -> sum=0x80, overflow=1, bypass=1'b0, latency 1, one result per cycle under continuous traffic.
